// File: rtl/interrupt_halt_controller.sv
// interrupt_halt_controller: IE flag, pending latches, priority vectoring and halt/wake
module interrupt_halt_controller #(
    parameter int          NUM_IRQ       = 4,
    parameter logic [15:0] VECTOR_BASE   = 16'h0004,
    parameter int          VECTOR_STRIDE = 4
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               COMMIT,
    input  logic               EIX,
    input  logic               DIX,
    input  logic               RETIX,
    input  logic               HALTX,
    input  logic [NUM_IRQ-1:0] IRQ,
    input  logic               INT_ACK,
    output logic               INT_REQ,
    output logic [15:0]        INT_VECTOR,
    output logic               IE,
    output logic               IN_SERVICE,
    output logic               HALTED,
    output logic [NUM_IRQ-1:0] PENDING
);
    typedef enum logic [1:0] {RUN, HALT, REQ, SERVICE} state_t;
    state_t state, state_nxt;
    logic [NUM_IRQ-1:0] irq_prev, rise, ack_clr;
    logic [2:0] sel, sel_q;
    logic [15:0] vec;
    logic take, ack, ret, halt_cmd, ei, di;
    assign rise     = IRQ & ~irq_prev;
    assign ei       = COMMIT & EIX;
    assign di       = COMMIT & DIX;
    assign halt_cmd = COMMIT & HALTX;
    assign ret      = COMMIT & RETIX & (state == SERVICE);
    assign ack      = INT_ACK & (state == REQ);
    assign take     = IE & ~IN_SERVICE & (|PENDING);
    assign ack_clr  = ack ? (NUM_IRQ'(1) << sel_q) : '0;
    assign vec      = VECTOR_BASE + 16'(32'(sel) * VECTOR_STRIDE);
    // lowest-numbered pending source has priority
    always_comb begin
        sel = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (PENDING[i]) sel = 3'(i);
    end
    // state register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= RUN;
        else          state <= state_nxt;
    end
    // next state: a request is only raised from RUN or HALT, and wakes a halted core
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     state_nxt = take ? REQ : halt_cmd ? HALT : RUN;
            HALT:    state_nxt = take ? REQ : HALT;
            REQ:     state_nxt = ack ? SERVICE : REQ;
            SERVICE: state_nxt = ret ? RUN : halt_cmd ? HALT : SERVICE;
        endcase
    end
    // outputs decoded straight from the registered state
    always_comb begin
        INT_REQ = (state == REQ);
        HALTED  = (state == HALT);
    end
    // edge history, pending latches, IE, service flag and the frozen vector
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            irq_prev   <= '0;
            PENDING    <= '0;
            IE         <= 1'b0;
            IN_SERVICE <= 1'b0;
            INT_VECTOR <= 16'h0000;
            sel_q      <= '0;
        end else begin
            irq_prev   <= IRQ;
            PENDING    <= (PENDING & ~ack_clr) | rise;
            IE         <= (ack || di) ? 1'b0 : (ei || ret) ? 1'b1 : IE;
            IN_SERVICE <= ack ? 1'b1 : ret ? 1'b0 : IN_SERVICE;
            if (state_nxt == REQ && state != REQ) begin
                sel_q      <= sel;
                INT_VECTOR <= vec;
            end
        end
    end
endmodule

// File: doc/interrupt_halt_controller.md
Name: interrupt_halt_controller

Overview:
- Consumes the EIX/DIX/RETIX/HALTX control strobes produced by the general instruction group decoder, i.e. the executing end of EI/DI/RETI/HALT.
- Owns the global interrupt-enable flag, per-source pending latches and priority selection.
- Runs a request/acknowledge handshake with the sequencer to vector into handlers, plus the halt/wake state.
- Sits between the instruction decoders and the fetch sequencer.

Parameters:
- NUM_IRQ, 4, number of interrupt sources (1..8); index 0 is highest priority.
- VECTOR_BASE, 16'h0004, address of the source-0 handler.
- VECTOR_STRIDE, 4, address increment between consecutive source vectors.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- COMMIT  in  1  instruction-commit strobe; EIX/DIX/RETIX/HALTX are sampled only when COMMIT=1.
- EIX  in  1  enable-interrupts instruction committed.
- DIX  in  1  disable-interrupts instruction committed.
- RETIX  in  1  return-from-interrupt instruction committed.
- HALTX  in  1  halt instruction committed.
- IRQ  in  NUM_IRQ  synchronous interrupt request lines, rising-edge sensitive.
- INT_ACK  in  1  sequencer accepts the request at an instruction boundary; one-cycle pulse.
- INT_REQ  out  1  interrupt request to the sequencer.
- INT_VECTOR  out  16  handler address; stable while INT_REQ=1.
- IE  out  1  global interrupt-enable flag.
- IN_SERVICE  out  1  a handler is executing.
- HALTED  out  1  core is halted; the sequencer stalls fetch.
- PENDING  out  NUM_IRQ  pending latches.

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - INT_REQ=0, INT_VECTOR=16'h0000, IE=0, IN_SERVICE=0, HALTED=0, PENDING=0.
  - IRQ edge-detect history = 0; FSM=RUN.
  - Reset mid-handshake or mid-halt abandons everything; no request survives.
- Edge detect:
  - PENDING[i] sets on the cycle after IRQ[i] goes 0->1 (registered previous value).
  - Set has priority over clear in the same cycle.
  - Pending latches accumulate regardless of IE or state.
- Instruction effects, taking effect the cycle after COMMIT=1 with the strobe high:
  - EIX sets IE to 1.
  - DIX clears IE to 0.
  - EIX and DIX both high: DIX wins, IE=0.
  - RETIX in SERVICE: IE=1, IN_SERVICE=0, FSM->RUN.
  - RETIX outside SERVICE: ignored.
  - HALTX in RUN: HALTED=1, FSM->HALT.
  - HALTX in SERVICE: HALTED=1 with IN_SERVICE kept; the wake rule still applies.
  - Strobes with COMMIT=0 are ignored.
- FSM states: RUN, HALT, REQ, SERVICE.
  - RUN: if IE=1, IN_SERVICE=0 and |PENDING:
    - select the lowest set index k;
    - INT_VECTOR <= VECTOR_BASE + k*VECTOR_STRIDE (16-bit, wraps modulo 2^16);
    - latch k; INT_REQ=1; ->REQ.
  - HALT: same entry condition as RUN; on meeting it, HALTED=0 and ->REQ with the same vector rule.
    - If IE=0 the core stays halted until reset; pending edges are still recorded.
  - REQ: INT_REQ held, INT_VECTOR frozen; a higher-priority edge arriving now does not change the vector.
    - On INT_ACK=1: INT_REQ=0, PENDING[k] cleared (unless a new edge on k sets it the same cycle), IE=0, IN_SERVICE=1, ->SERVICE.
    - DIX committed while in REQ does not withdraw the request; IE becomes 0 and the ACK still completes.
  - SERVICE: no nesting; new edges only pend. Leaves via RETIX.
- INT_ACK outside REQ is ignored.
- Latency:
  - IRQ edge -> PENDING: 1 cycle.
  - PENDING -> INT_REQ: 1 cycle.
  - Minimum IRQ edge -> INT_REQ: 2 cycles.
  - INT_ACK -> IN_SERVICE=1: 1 cycle.

Test Plan:
- Reset then IRQ=4'b0100 edge with IE=0 -> PENDING=4'b0100, INT_REQ stays 0. Then commit EIX -> INT_REQ=1 within 2 cycles, INT_VECTOR=16'h000C.
- IE=1, IRQ[3] and IRQ[1] edges in the same cycle -> INT_VECTOR=16'h0008 (source 1). INT_ACK -> PENDING=4'b1000, IE=0, IN_SERVICE=1. RETIX -> second request with INT_VECTOR=16'h0010.
- IE=1, HALTX committed -> HALTED=1. IRQ[0] edge 5 cycles later -> HALTED=0, INT_REQ=1, INT_VECTOR=16'h0004. Repeat with IE=0 -> HALTED remains 1 for 50 cycles.
- COMMIT with EIX=1 and DIX=1 together -> IE=0. EIX with COMMIT=0 -> IE unchanged.
- In REQ for source 2, an IRQ[0] edge arrives before INT_ACK -> vector stays 16'h000C, PENDING[0]=1 after ACK.
- RESET_N pulsed low while INT_REQ=1 and PENDING nonzero -> all outputs 0 immediately (asynchronously), no request after release.
